// File: rtl/mar_burst_sequencer.sv
// Memory address register with a burst engine: it loads a base address and then
// presents load_len+1 strided addresses over a valid/ready handshake.
// Optional macro MAR_WRAP_EN confines the increment to an aligned 2^WRAP_LOG2 window.
module mar_burst_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 8,
  parameter int STRIDE    = 1,
  parameter int WRAP_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_inc;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic load_hit;
  logic abort_hit;
  logic beat_xfer;
  logic last_beat;

  assign load_hit  = (state_q == ST_IDLE) && load_valid;
  assign abort_hit = (state_q == ST_BURST) && abort;
  // Abort wins over a beat offered in the same cycle: that beat is not accepted.
  assign beat_xfer = valid_q && addr_ready && !abort_hit;
  assign last_beat = beat_xfer && (count_q == '0);

`ifdef MAR_WRAP_EN
  localparam logic [WRAP_LOG2-1:0] STRIDE_LO = WRAP_LOG2'(STRIDE);

  assign addr_inc = {addr_q[ADDR_W-1:WRAP_LOG2], addr_q[WRAP_LOG2-1:0] + STRIDE_LO};
`else
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  assign addr_inc = addr_q + STRIDE_A;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_hit) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (abort_hit || last_beat) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs of the FSM
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE:  load_ready = 1'b1;
      ST_BURST: busy       = 1'b1;
      default: begin
        load_ready = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

  // Datapath: address, remaining beat count, handshake valid and done pulse
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (load_hit) begin
          addr_d  = load_addr;
          count_d = load_len;
          valid_d = 1'b1;
        end
      end
      ST_BURST: begin
        if (abort_hit || last_beat) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else if (beat_xfer) begin
          addr_d  = addr_inc;
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign done       = done_q;

endmodule
